// File: rtl/cl_ocl_cfg_bridge_pkg.sv
// Shared types and constants for the OCL AXI4-Lite to cfg-bus bridge.
// State encodings, AXI response codes and the arbitration priority value.
package cl_ocl_cfg_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_WAIT = 3'd1,
        RD_WAIT = 3'd2,
        WR_RESP = 3'd3,
        RD_RESP = 3'd4
    } bridge_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic PRI_WRITE = 1'b0;

    // The cfg bus carries whole words only, so partial strobes are rejected.
    function automatic logic strb_is_full(input logic [3:0] strb);
        return (strb == 4'hF);
    endfunction

endpackage

// File: rtl/cl_ocl_cfg_bridge_if.sv
// AXI4-Lite channel bundle between an OCL master and the cfg bridge.
interface cl_ocl_cfg_bridge_if;

    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
               s_rdata, s_rresp, s_rvalid
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
               s_rdata, s_rresp, s_rvalid
    );

endinterface

// File: rtl/cl_axil_hold_reg.sv
// One-entry valid/ready holding register; ready is simply !full.
// The consumer frees the entry with a single-cycle pop while it is full.
module cl_axil_hold_reg #(
    parameter int W = 32
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_full,
    output logic [W-1:0] o_data
);

    logic         r_full;
    logic [W-1:0] r_data;

    // Load and pop are mutually exclusive: loads need empty, pops need full.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_ready = !r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/cl_ocl_cfg_bridge.sv
// AXI4-Lite slave turning OCL register accesses into single cfg-bus transactions,
// one outstanding at a time, with a timeout that completes absent acks as SLVERR.
module cl_ocl_cfg_bridge
    import cl_ocl_cfg_bridge_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_DEAD
) (
    input  logic                      aclk,
    input  logic                      areset,
    cl_ocl_cfg_bridge_if.slave        s_axil,
    output logic [31:0]               cfg_addr,
    output logic [31:0]               cfg_wdata,
    output logic                      cfg_wr,
    output logic                      cfg_rd,
    input  logic                      cfg_ack,
    input  logic [31:0]               cfg_rdata
);

    localparam logic [2:0]  S_IDLE    = IDLE;
    localparam logic [2:0]  S_WR_WAIT = WR_WAIT;
    localparam logic [2:0]  S_RD_WAIT = RD_WAIT;
    localparam logic [2:0]  S_WR_RESP = WR_RESP;
    localparam logic [2:0]  S_RD_RESP = RD_RESP;
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    logic        w_awready, w_wready, w_arready;
    logic        w_aw_full, w_w_full, w_ar_full;
    logic [31:0] w_aw_addr, w_ar_addr;
    logic [35:0] w_w_data;
    logic        w_wr_rdy, w_rd_rdy, w_grant_wr, w_grant_rd, w_tmo_hit;

    logic [2:0]  r_state;
    logic        r_rr_pri;
    logic [15:0] r_tmo_cnt;
    logic        r_cfg_wr, r_cfg_rd, r_bvalid, r_rvalid;
    logic [1:0]  r_bresp, r_rresp;
    logic [31:0] r_rdata, r_cfg_addr, r_cfg_wdata;

    cl_axil_hold_reg #(.W(32)) u_aw_hold (
        .aclk    (aclk),
        .areset  (areset),
        .i_valid (s_axil.s_awvalid),
        .o_ready (w_awready),
        .i_data  (s_axil.s_awaddr),
        .i_pop   (w_grant_wr),
        .o_full  (w_aw_full),
        .o_data  (w_aw_addr)
    );

    cl_axil_hold_reg #(.W(36)) u_w_hold (
        .aclk    (aclk),
        .areset  (areset),
        .i_valid (s_axil.s_wvalid),
        .o_ready (w_wready),
        .i_data  ({s_axil.s_wstrb, s_axil.s_wdata}),
        .i_pop   (w_grant_wr),
        .o_full  (w_w_full),
        .o_data  (w_w_data)
    );

    cl_axil_hold_reg #(.W(32)) u_ar_hold (
        .aclk    (aclk),
        .areset  (areset),
        .i_valid (s_axil.s_arvalid),
        .o_ready (w_arready),
        .i_data  (s_axil.s_araddr),
        .i_pop   (w_grant_rd),
        .o_full  (w_ar_full),
        .o_data  (w_ar_addr)
    );

    // Grants are only issued from IDLE; the grant doubles as the holding-reg pop.
    assign w_wr_rdy   = w_aw_full && w_w_full;
    assign w_rd_rdy   = w_ar_full;
    assign w_grant_wr = (r_state == S_IDLE) && w_wr_rdy && (!w_rd_rdy || (r_rr_pri == PRI_WRITE));
    assign w_grant_rd = (r_state == S_IDLE) && w_rd_rdy && !w_grant_wr;
    assign w_tmo_hit  = (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state     <= S_IDLE;
            r_rr_pri    <= PRI_WRITE;
            r_tmo_cnt   <= '0;
            r_cfg_wr    <= 1'b0;
            r_cfg_rd    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_rvalid    <= 1'b0;
            r_bresp     <= RESP_OKAY;
            r_rresp     <= RESP_OKAY;
            r_rdata     <= '0;
            r_cfg_addr  <= '0;
            r_cfg_wdata <= '0;
        end else begin
            r_cfg_wr <= 1'b0;
            r_cfg_rd <= 1'b0;
            if (((r_state == S_WR_WAIT) || (r_state == S_RD_WAIT)) && (r_tmo_cnt != 16'hFFFF))
                r_tmo_cnt <= r_tmo_cnt + 16'd1;

            case (r_state)
                S_IDLE: begin
                    r_tmo_cnt <= '0;
                    if (w_grant_wr) begin
                        r_rr_pri <= ~r_rr_pri;
                        if (strb_is_full(w_w_data[35:32])) begin
                            r_state     <= S_WR_WAIT;
                            r_cfg_wr    <= 1'b1;
                            r_cfg_addr  <= w_aw_addr;
                            r_cfg_wdata <= w_w_data[31:0];
                        end else begin
                            r_state  <= S_WR_RESP;
                            r_bvalid <= 1'b1;
                            r_bresp  <= RESP_SLVERR;
                        end
                    end else if (w_grant_rd) begin
                        r_rr_pri   <= ~r_rr_pri;
                        r_state    <= S_RD_WAIT;
                        r_cfg_rd   <= 1'b1;
                        r_cfg_addr <= w_ar_addr;
                    end
                end
                // An ack landing on the terminal count still completes OKAY.
                S_WR_WAIT: begin
                    if (cfg_ack) begin
                        r_state  <= S_WR_RESP;
                        r_bvalid <= 1'b1;
                        r_bresp  <= RESP_OKAY;
                    end else if (w_tmo_hit) begin
                        r_state  <= S_WR_RESP;
                        r_bvalid <= 1'b1;
                        r_bresp  <= RESP_SLVERR;
                    end
                end
                S_RD_WAIT: begin
                    if (cfg_ack) begin
                        r_state  <= S_RD_RESP;
                        r_rvalid <= 1'b1;
                        r_rdata  <= cfg_rdata;
                        r_rresp  <= RESP_OKAY;
                    end else if (w_tmo_hit) begin
                        r_state  <= S_RD_RESP;
                        r_rvalid <= 1'b1;
                        r_rdata  <= TIMEOUT_RDATA;
                        r_rresp  <= RESP_SLVERR;
                    end
                end
                S_WR_RESP: begin
                    if (s_axil.s_bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_RD_RESP: begin
                    if (s_axil.s_rready) begin
                        r_rvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_axil.s_awready = w_awready;
    assign s_axil.s_wready  = w_wready;
    assign s_axil.s_arready = w_arready;
    assign s_axil.s_bvalid  = r_bvalid;
    assign s_axil.s_bresp   = r_bresp;
    assign s_axil.s_rvalid  = r_rvalid;
    assign s_axil.s_rresp   = r_rresp;
    assign s_axil.s_rdata   = r_rdata;
    assign cfg_addr         = r_cfg_addr;
    assign cfg_wdata        = r_cfg_wdata;
    assign cfg_wr           = r_cfg_wr;
    assign cfg_rd           = r_cfg_rd;

endmodule

// File: tb/tb_cl_ocl_cfg_bridge.sv
// Directed bench for cl_ocl_cfg_bridge: hand-timed AXI-L and cfg-bus stimulus,
// every comparison an immediate assertion against a hand-computed value.
module tb_cl_ocl_cfg_bridge;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] cfg_addr, cfg_wdata, cfg_rdata;
    logic        cfg_wr, cfg_rd, cfg_ack;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wr     = 0;
    int n_rd     = 0;

    cl_ocl_cfg_bridge_if axil ();

    cl_ocl_cfg_bridge #(
        .TIMEOUT_CYCLES (16),
        .TIMEOUT_RDATA  (32'hDEAD_DEAD)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_axil    (axil),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_wr    (cfg_wr),
        .cfg_rd    (cfg_rd),
        .cfg_ack   (cfg_ack),
        .cfg_rdata (cfg_rdata)
    );

    always #5 aclk = ~aclk;

    // Pulse counters: each sampled edge with the strobe high is one cycle of pulse.
    always @(posedge aclk) begin
        if (cfg_wr) n_wr++;
        if (cfg_rd) n_rd++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    int early;
    int activity;

    initial begin
        areset          = 1'b1;
        cfg_ack         = 1'b0;
        cfg_rdata       = '0;
        axil.s_awaddr   = '0;
        axil.s_awvalid  = 1'b0;
        axil.s_wdata    = '0;
        axil.s_wstrb    = 4'h0;
        axil.s_wvalid   = 1'b0;
        axil.s_bready   = 1'b0;
        axil.s_araddr   = '0;
        axil.s_arvalid  = 1'b0;
        axil.s_rready   = 1'b0;
        tick();
        tick();
        areset = 1'b0;
        tick();

        // Reset state
        chk("rst_awready", 32'(axil.s_awready), 32'd1);
        chk("rst_wready",  32'(axil.s_wready),  32'd1);
        chk("rst_arready", 32'(axil.s_arready), 32'd1);
        chk("rst_bvalid",  32'(axil.s_bvalid),  32'd0);
        chk("rst_rvalid",  32'(axil.s_rvalid),  32'd0);
        chk("rst_cfg_wr",  32'(cfg_wr),         32'd0);
        chk("rst_cfg_rd",  32'(cfg_rd),         32'd0);
        chk("rst_cfg_addr", cfg_addr,           32'd0);
        chk("rst_rdata",   axil.s_rdata,        32'd0);

        // 1: write 0x0C <- 0x12345678, AW three cycles ahead of W, ack 4 cycles after cfg_wr
        axil.s_awaddr  = 32'h0000_000C;
        axil.s_awvalid = 1'b1;
        tick();
        axil.s_awvalid = 1'b0;
        chk("t1_awready_held", 32'(axil.s_awready), 32'd0);
        tick();
        tick();
        axil.s_wdata  = 32'h1234_5678;
        axil.s_wstrb  = 4'hF;
        axil.s_wvalid = 1'b1;
        tick();
        axil.s_wvalid = 1'b0;
        chk("t1_wready_held", 32'(axil.s_wready), 32'd0);
        chk("t1_no_early_wr", 32'(cfg_wr), 32'd0);
        tick();
        chk("t1_cfg_wr",    32'(cfg_wr), 32'd1);
        chk("t1_cfg_addr",  cfg_addr,    32'h0000_000C);
        chk("t1_cfg_wdata", cfg_wdata,   32'h1234_5678);
        chk("t1_awready_freed", 32'(axil.s_awready), 32'd1);
        tick();
        chk("t1_cfg_wr_single", 32'(cfg_wr), 32'd0);
        tick();
        tick();
        tick();
        cfg_ack = 1'b1;
        chk("t1_bvalid_before_ack", 32'(axil.s_bvalid), 32'd0);
        tick();
        cfg_ack = 1'b0;
        chk("t1_bvalid", 32'(axil.s_bvalid), 32'd1);
        chk("t1_bresp",  32'(axil.s_bresp),  32'd0);
        chk("t1_addr_held", cfg_addr, 32'h0000_000C);
        axil.s_bready = 1'b1;
        tick();
        axil.s_bready = 1'b0;
        chk("t1_bvalid_clr", 32'(axil.s_bvalid), 32'd0);
        chk("t1_wr_pulses", 32'(n_wr), 32'd1);

        // 2: read 0x10, ack with 0xCAFEF00D, rready held low 5 cycles
        axil.s_araddr  = 32'h0000_0010;
        axil.s_arvalid = 1'b1;
        tick();
        axil.s_arvalid = 1'b0;
        chk("t2_arready_held", 32'(axil.s_arready), 32'd0);
        tick();
        chk("t2_cfg_rd",   32'(cfg_rd), 32'd1);
        chk("t2_cfg_addr", cfg_addr,    32'h0000_0010);
        chk("t2_arready_freed", 32'(axil.s_arready), 32'd1);
        tick();
        cfg_ack   = 1'b1;
        cfg_rdata = 32'hCAFE_F00D;
        chk("t2_cfg_rd_single", 32'(cfg_rd), 32'd0);
        tick();
        cfg_ack   = 1'b0;
        cfg_rdata = 32'h0;
        chk("t2_rvalid", 32'(axil.s_rvalid), 32'd1);
        chk("t2_rdata",  axil.s_rdata,       32'hCAFE_F00D);
        chk("t2_rresp",  32'(axil.s_rresp),  32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_rvalid_hold", 32'(axil.s_rvalid), 32'd1);
            chk("t2_rdata_hold",  axil.s_rdata,       32'hCAFE_F00D);
        end
        axil.s_rready = 1'b1;
        tick();
        axil.s_rready = 1'b0;
        chk("t2_rvalid_clr", 32'(axil.s_rvalid), 32'd0);

        // 3: read with no ack, timeout after 16 cycles, stale ack afterwards ignored
        axil.s_araddr  = 32'h0000_0020;
        axil.s_arvalid = 1'b1;
        tick();
        axil.s_arvalid = 1'b0;
        tick();
        chk("t3_cfg_rd", 32'(cfg_rd), 32'd1);
        early = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (axil.s_rvalid) early++;
        end
        chk("t3_no_early_rvalid", 32'(early), 32'd0);
        tick();
        chk("t3_rvalid", 32'(axil.s_rvalid), 32'd1);
        chk("t3_rdata",  axil.s_rdata,       32'hDEAD_DEAD);
        chk("t3_rresp",  32'(axil.s_rresp),  32'd2);
        cfg_ack   = 1'b1;
        cfg_rdata = 32'h1111_1111;
        tick();
        cfg_ack   = 1'b0;
        chk("t3_stale_rdata", axil.s_rdata,      32'hDEAD_DEAD);
        chk("t3_stale_rresp", 32'(axil.s_rresp), 32'd2);
        axil.s_rready = 1'b1;
        tick();
        axil.s_rready = 1'b0;
        chk("t3_rvalid_clr", 32'(axil.s_rvalid), 32'd0);
        cfg_ack = 1'b1;
        tick();
        cfg_ack = 1'b0;
        tick();
        chk("t3_idle_ack_bvalid", 32'(axil.s_bvalid), 32'd0);
        chk("t3_idle_ack_rvalid", 32'(axil.s_rvalid), 32'd0);
        chk("t3_rd_pulses", 32'(n_rd), 32'd2);

        // 4: write with wstrb=3 rejected, queued read then proceeds
        axil.s_awaddr  = 32'h0000_0040;
        axil.s_wdata   = 32'hAAAA_AAAA;
        axil.s_wstrb   = 4'h3;
        axil.s_awvalid = 1'b1;
        axil.s_wvalid  = 1'b1;
        tick();
        axil.s_awvalid = 1'b0;
        axil.s_wvalid  = 1'b0;
        axil.s_araddr  = 32'h0000_0044;
        axil.s_arvalid = 1'b1;
        tick();
        axil.s_arvalid = 1'b0;
        chk("t4_bvalid",  32'(axil.s_bvalid),  32'd1);
        chk("t4_bresp",   32'(axil.s_bresp),   32'd2);
        chk("t4_no_wr",   32'(cfg_wr),         32'd0);
        chk("t4_awready", 32'(axil.s_awready), 32'd1);
        chk("t4_wready",  32'(axil.s_wready),  32'd1);
        chk("t4_arready", 32'(axil.s_arready), 32'd0);
        axil.s_bready = 1'b1;
        tick();
        axil.s_bready = 1'b0;
        chk("t4_bvalid_clr", 32'(axil.s_bvalid), 32'd0);
        tick();
        chk("t4_cfg_rd",   32'(cfg_rd), 32'd1);
        chk("t4_cfg_addr", cfg_addr,    32'h0000_0044);
        chk("t4_wr_pulses", 32'(n_wr),  32'd1);
        tick();
        cfg_ack   = 1'b1;
        cfg_rdata = 32'h0055_AA00;
        tick();
        cfg_ack   = 1'b0;
        chk("t4_rvalid", 32'(axil.s_rvalid), 32'd1);
        chk("t4_rdata",  axil.s_rdata,       32'h0055_AA00);
        chk("t4_rresp",  32'(axil.s_rresp),  32'd0);
        axil.s_rready = 1'b1;
        tick();
        axil.s_rready = 1'b0;

        // 6: reset while in RD_WAIT abandons the read
        axil.s_araddr  = 32'h0000_0030;
        axil.s_arvalid = 1'b1;
        tick();
        axil.s_arvalid = 1'b0;
        tick();
        chk("t6_cfg_rd", 32'(cfg_rd), 32'd1);
        #1;
        areset = 1'b1;
        #1;
        chk("t6_rst_cfg_rd",   32'(cfg_rd),         32'd0);
        chk("t6_rst_rvalid",   32'(axil.s_rvalid),  32'd0);
        chk("t6_rst_cfg_addr", cfg_addr,            32'd0);
        tick();
        tick();
        areset = 1'b0;
        tick();
        chk("t6_awready", 32'(axil.s_awready), 32'd1);
        chk("t6_wready",  32'(axil.s_wready),  32'd1);
        chk("t6_arready", 32'(axil.s_arready), 32'd1);
        cfg_ack  = 1'b1;
        activity = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cfg_ack = 1'b0;
            if (axil.s_rvalid || axil.s_bvalid || cfg_rd || cfg_wr) activity++;
        end
        chk("t6_no_response", 32'(activity), 32'd0);

        // 5: write+read together twice; priority alternates, each pulse waits for the prior handshake
        axil.s_awaddr  = 32'h0000_0050;
        axil.s_wdata   = 32'h5050_5050;
        axil.s_wstrb   = 4'hF;
        axil.s_araddr  = 32'h0000_0054;
        axil.s_awvalid = 1'b1;
        axil.s_wvalid  = 1'b1;
        axil.s_arvalid = 1'b1;
        tick();
        axil.s_awvalid = 1'b0;
        axil.s_wvalid  = 1'b0;
        axil.s_arvalid = 1'b0;
        chk("t5_arready_held", 32'(axil.s_arready), 32'd0);
        tick();
        chk("t5a_cfg_wr",   32'(cfg_wr), 32'd1);
        chk("t5a_cfg_rd",   32'(cfg_rd), 32'd0);
        chk("t5a_cfg_addr", cfg_addr,    32'h0000_0050);
        axil.s_awaddr  = 32'h0000_0060;
        axil.s_wdata   = 32'h6060_6060;
        axil.s_awvalid = 1'b1;
        axil.s_wvalid  = 1'b1;
        tick();
        axil.s_awvalid = 1'b0;
        axil.s_wvalid  = 1'b0;
        cfg_ack = 1'b1;
        chk("t5_aw2_held", 32'(axil.s_awready), 32'd0);
        tick();
        cfg_ack = 1'b0;
        chk("t5a_bvalid", 32'(axil.s_bvalid), 32'd1);
        axil.s_bready = 1'b1;
        tick();
        axil.s_bready = 1'b0;
        chk("t5b_rd_waits", 32'(cfg_rd), 32'd0);
        tick();
        chk("t5b_cfg_rd",   32'(cfg_rd), 32'd1);
        chk("t5b_cfg_wr",   32'(cfg_wr), 32'd0);
        chk("t5b_cfg_addr", cfg_addr,    32'h0000_0054);
        axil.s_araddr  = 32'h0000_0064;
        axil.s_arvalid = 1'b1;
        tick();
        axil.s_arvalid = 1'b0;
        cfg_ack   = 1'b1;
        cfg_rdata = 32'h0000_5454;
        tick();
        cfg_ack = 1'b0;
        chk("t5b_rvalid", 32'(axil.s_rvalid), 32'd1);
        chk("t5b_rdata",  axil.s_rdata,       32'h0000_5454);
        axil.s_rready = 1'b1;
        tick();
        axil.s_rready = 1'b0;
        chk("t5c_wr_waits", 32'(cfg_wr), 32'd0);
        tick();
        chk("t5c_cfg_wr",    32'(cfg_wr), 32'd1);
        chk("t5c_cfg_rd",    32'(cfg_rd), 32'd0);
        chk("t5c_cfg_addr",  cfg_addr,    32'h0000_0060);
        chk("t5c_cfg_wdata", cfg_wdata,   32'h6060_6060);
        tick();
        cfg_ack = 1'b1;
        tick();
        cfg_ack = 1'b0;
        chk("t5c_bvalid", 32'(axil.s_bvalid), 32'd1);
        chk("t5c_bresp",  32'(axil.s_bresp),  32'd0);
        axil.s_bready = 1'b1;
        tick();
        axil.s_bready = 1'b0;
        chk("t5d_rd_waits", 32'(cfg_rd), 32'd0);
        tick();
        chk("t5d_cfg_rd",   32'(cfg_rd), 32'd1);
        chk("t5d_cfg_addr", cfg_addr,    32'h0000_0064);
        tick();
        cfg_ack   = 1'b1;
        cfg_rdata = 32'h0000_6464;
        tick();
        cfg_ack = 1'b0;
        chk("t5d_rvalid", 32'(axil.s_rvalid), 32'd1);
        chk("t5d_rdata",  axil.s_rdata,       32'h0000_6464);
        axil.s_rready = 1'b1;
        tick();
        axil.s_rready = 1'b0;
        chk("t5d_rvalid_clr", 32'(axil.s_rvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
